// File: rtl/inst_demux_pkg.sv
// inst_demux_pkg: shared constants and types for the N-channel instruction-fetch demux.
package inst_demux_pkg;
  localparam int PAGE_W = 20;
  localparam int PAGE_LSB = 12;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} demux_state_e;
  typedef logic [31:0] inst_addr_t;
endpackage

// File: rtl/inst_page_decoder.sv
// inst_page_decoder: maps a 4KB page onto a one-hot channel select, lowest index wins on overlap.
module inst_page_decoder
  import inst_demux_pkg::*;
#(
  parameter int NUM_CH = 3
) (
  input  logic [PAGE_W-1:0]             page,
  input  logic [NUM_CH-1:0][PAGE_W-1:0] base_pg,
  input  logic [NUM_CH-1:0][PAGE_W-1:0] end_pg,
  output logic [NUM_CH-1:0]             sel,
  output logic                          hit
);
  always_comb begin
    sel = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (page >= base_pg[i] && page <= end_pg[i]) sel = NUM_CH'(1) << i;
  end
  assign hit = |sel;
endmodule

// File: rtl/inst_itf_demux_n.sv
// inst_itf_demux_n: routes one core fetch to one of NUM_CH instruction ports, single outstanding.
// Define INST_DEMUX_TIMEOUT_EN to add a WAIT-state watchdog of TIMEOUT_CYCLES cycles.
module inst_itf_demux_n
  import inst_demux_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter logic [NUM_CH-1:0][PAGE_W-1:0] CH_BASE_PG = {20'h00000, 20'h00010, 20'h80000},
  parameter logic [NUM_CH-1:0][PAGE_W-1:0] CH_END_PG = {20'h00000, 20'h0001F, 20'hFFFFF},
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     inst_core_req_i,
  input  logic [31:0]              inst_core_addr_i,
  output logic                     inst_core_ack_o,
  output logic                     inst_core_error_o,
  output logic [31:0]              inst_core_data_o,
  output logic [NUM_CH-1:0]        inst_ch_req_o,
  output logic [NUM_CH-1:0][31:0]  inst_ch_addr_o,
  input  logic [NUM_CH-1:0]        inst_ch_ack_i,
  input  logic [NUM_CH-1:0]        inst_ch_error_i,
  input  logic [NUM_CH-1:0][31:0]  inst_ch_data_i,
  output logic                     busy_o
);
  demux_state_e state, state_nx;
  inst_addr_t addr_q;
  logic [NUM_CH-1:0] sel_q, dec_sel;
  logic dec_hit, sel_ack, sel_err, err_q, expire;
  logic [31:0] sel_data, data_q;

  inst_page_decoder #(.NUM_CH(NUM_CH)) u_dec (
    .page    (inst_core_addr_i[PAGE_LSB +: PAGE_W]),
    .base_pg (CH_BASE_PG),
    .end_pg  (CH_END_PG),
    .sel     (dec_sel),
    .hit     (dec_hit)
  );

  always_comb begin
    sel_data = '0;
    sel_err = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      if (sel_q[i]) begin
        sel_data |= inst_ch_data_i[i];
        sel_err |= inst_ch_error_i[i];
      end
  end
  assign sel_ack = |(inst_ch_ack_i & sel_q);

`ifdef INST_DEMUX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  assign expire = state == WAIT && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk_i)
    if (rst_i || state != WAIT) cnt <= '0;
    else cnt <= cnt + 1'b1;
`else
  assign expire = 1'b0;
`endif

  always_comb
    state_nx = (state == IDLE) ? (inst_core_req_i ? (dec_hit ? WAIT : RESP) : IDLE)
             : (state == WAIT) ? ((sel_ack || expire) ? RESP : WAIT)
             : IDLE;

  always_ff @(posedge clk_i)
    if (rst_i) begin
      state <= IDLE;
      addr_q <= '0;
      sel_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && inst_core_req_i) begin
        addr_q <= inst_core_addr_i;
        sel_q <= dec_sel;
        if (!dec_hit) begin
          data_q <= '0;
          err_q <= 1'b1;
        end
      end
      // a same-cycle ack beats watchdog expiry
      if (state == WAIT && (sel_ack || expire)) begin
        data_q <= sel_ack ? sel_data : '0;
        err_q <= sel_ack ? sel_err : 1'b1;
      end
    end

  assign inst_ch_req_o = (state == WAIT) ? sel_q : '0;
  assign inst_ch_addr_o = {NUM_CH{addr_q}};
  assign inst_core_ack_o = state == RESP;
  assign inst_core_data_o = data_q;
  assign inst_core_error_o = err_q;
  assign busy_o = state != IDLE;
endmodule

// File: tb/tb_inst_itf_demux_n.sv
// tb_inst_itf_demux_n: scoreboard bench for inst_itf_demux_n; honours INST_DEMUX_TIMEOUT_EN.
module tb_inst_itf_demux_n;
  localparam logic [2:0][19:0] BASE = {20'h80000, 20'h00010, 20'h80000};
  localparam logic [2:0][19:0] ENDP = {20'hFFFFF, 20'h0001F, 20'h80000};
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic core_req = 1'b0, core_ack, core_err, busy;
  logic [31:0] core_addr = '0, core_data;
  logic [2:0] ch_req, ch_ack = '0, ch_err = '0;
  logic [2:0][31:0] ch_addr, ch_data = '0;
  logic [32:0] exp_q[$];
  int n_cmp = 0, n_err = 0;

  inst_itf_demux_n #(.NUM_CH(3), .CH_BASE_PG(BASE), .CH_END_PG(ENDP), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .inst_core_req_i(core_req), .inst_core_addr_i(core_addr),
    .inst_core_ack_o(core_ack), .inst_core_error_o(core_err), .inst_core_data_o(core_data),
    .inst_ch_req_o(ch_req), .inst_ch_addr_o(ch_addr),
    .inst_ch_ack_i(ch_ack), .inst_ch_error_i(ch_err), .inst_ch_data_i(ch_data),
    .busy_o(busy)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  always @(negedge clk_i)
    if (!rst_i && core_ack) begin
      if (exp_q.size() == 0) chk("unexpected_ack", 1, 0);
      else chk("resp", {core_err, core_data}, exp_q.pop_front());
    end

  // ch < 0 means unmapped; the selected channel acks in cycle k, optional stray ack elsewhere in cycle stray
  task automatic fetch(input logic [31:0] a, input int ch, input int k, input logic [31:0] d,
                       input logic e, input int stray);
    logic [2:0] oh;
    int so;
    oh = (ch < 0) ? 3'b000 : 3'(1 << ch);
    so = (ch == 0) ? 1 : 0;
    exp_q.push_back({e, d});
    core_req = 1'b1;
    core_addr = a;
    step();
    core_addr = ~a;
    if (ch < 0) begin
      chk("miss_ack", core_ack, 1);
      chk("miss_chreq", ch_req, 0);
    end else begin
      for (int c = 1; c <= k; c++) begin
        if (c > 1) step();
        ch_ack = '0;
        chk("ch_req", ch_req, oh);
        chk("ch_addr", ch_addr[ch], a);
        chk("busy", busy, 1);
        chk("early_ack", core_ack, 0);
        if (c == stray) begin
          ch_ack[so] = 1'b1;
          ch_data[so] = 32'h5A5A5A5A;
          ch_err[so] = 1'b1;
        end
        if (c == k) begin
          ch_ack[ch] = 1'b1;
          ch_data[ch] = d;
          ch_err[ch] = e;
        end
      end
      step();
      ch_ack = '0;
      chk("core_ack", core_ack, 1);
      chk("chreq_drop", ch_req, 0);
    end
    core_req = 1'b0;
    step();
    chk("idle_busy", busy, 0);
    chk("ack_clr", core_ack, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    step();
    step();
    chk("rst_ack", core_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_chreq", ch_req, 0);
    chk("rst_data", {core_err, core_data}, 0);
    chk("rst_addr", ch_addr, 0);
    rst_i = 1'b0;
    step();
    fetch(32'h00012344, 1, 3, 32'hDEADBEEF, 1'b0, 0);
    fetch(32'h00030000, -1, 0, 32'h0, 1'b1, 0);
    fetch(32'h80000000, 0, 1, 32'h13572468, 1'b0, 0);
    fetch(32'h90000000, 2, 4, 32'hCAFEF00D, 1'b0, 2);
    fetch(32'h0001F000, 1, 2, 32'h0BADC0DE, 1'b1, 1);
    chk("hold_data", {core_err, core_data}, {1'b1, 32'h0BADC0DE});
    ch_ack[1] = 1'b1;
    step();
    ch_ack = '0;
    chk("idle_stray_busy", busy, 0);
    step();
    chk("idle_stray_ack", core_ack, 0);
    core_req = 1'b1;
    core_addr = 32'h00012000;
    step();
    step();
    rst_i = 1'b1;
    core_req = 1'b0;
    step();
    rst_i = 1'b0;
    chk("mid_rst_chreq", ch_req, 0);
    chk("mid_rst_busy", busy, 0);
    ch_ack[1] = 1'b1;
    ch_data[1] = 32'h77777777;
    step();
    ch_ack = '0;
    step();
    chk("late_ack_core", core_ack, 0);
    chk("late_ack_busy", busy, 0);
    chk("late_ack_chreq", ch_req, 0);
`ifdef INST_DEMUX_TIMEOUT_EN
    exp_q.push_back({1'b1, 32'h0});
    core_req = 1'b1;
    core_addr = 32'h80000400;
    for (int c = 1; c <= 8; c++) begin
      step();
      chk("to_chreq", ch_req, 3'b001);
    end
    step();
    chk("to_ack", core_ack, 1);
    chk("to_chreq_drop", ch_req, 0);
    core_req = 1'b0;
    step();
    chk("to_idle", busy, 0);
`else
    core_req = 1'b1;
    core_addr = 32'h80000400;
    for (int c = 1; c <= 20; c++) step();
    chk("no_to_busy", busy, 1);
    chk("no_to_chreq", ch_req, 3'b001);
    chk("no_to_ack", core_ack, 0);
    rst_i = 1'b1;
    core_req = 1'b0;
    step();
    rst_i = 1'b0;
    chk("no_to_rst", busy, 0);
`endif
    step();
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/inst_itf_demux_n.md
Name: inst_itf_demux_n

Overview:
- Parametrised N-channel successor to the two-way instruction-fetch demux.
- Routes one core instruction request to one of NUM_CH downstream instruction ports, using a 4KB-page address map.
- Tracks a single outstanding transaction and returns ack/error/data through a registered response stage.
- Answers unmapped addresses internally with an error response.
- Sits between the Sophon fetch port and ITCM / external-memory / boot-ROM instruction ports, all in one clock domain.

Parameters:
- NUM_CH, 3: number of downstream channels (1..8).
- CH_BASE_PG, {20'h00000,20'h00010,20'h80000}: per-channel base page, addr[31:12]; packed array NUM_CH x 20.
- CH_END_PG, {20'h00000,20'h0001F,20'hFFFFF}: per-channel inclusive end page; packed array NUM_CH x 20.
- TIMEOUT_CYCLES, 256: watchdog limit in cycles (used only with the macro).

Ports:
- clk_i  in  1  clock; the only clock.
- rst_i  in  1  reset; synchronous, active-high.
- inst_core_req_i  in  1  core fetch request; held high until inst_core_ack_o.
- inst_core_addr_i  in  32  fetch address; stable while req is high.
- inst_core_ack_o  out  1  one-cycle response pulse.
- inst_core_error_o  out  1  error qualifier, valid with ack.
- inst_core_data_o  out  32  instruction, valid with ack.
- inst_ch_req_o  out  NUM_CH  per-channel request, registered, held until that channel's ack.
- inst_ch_addr_o  out  NUM_CH x 32  per-channel address; all channels carry the latched address.
- inst_ch_ack_i  in  NUM_CH  per-channel ack.
- inst_ch_error_i  in  NUM_CH  per-channel error, sampled with ack.
- inst_ch_data_i  in  NUM_CH x 32  per-channel data, sampled with ack.
- busy_o  out  1  high whenever state != IDLE.

Behaviour:
- Reset: state IDLE; all outputs 0; latched address 0; sel 0.
- Address decode on addr[31:12]:
  - Channel i hits if CH_BASE_PG[i] <= page <= CH_END_PG[i].
  - If several channels hit, the lowest index wins.
  - If no channel hits, the request is a decode error.
- FSM IDLE, in cycle 0 with req=1:
  - Latch addr and the one-hot sel.
  - On a hit, go to WAIT and set inst_ch_req_o[sel]=1 from cycle 1.
  - On a miss, go to RESP with error=1 and data=0.
- FSM WAIT, when inst_ch_ack_i[sel]=1:
  - Clear inst_ch_req_o at the next edge.
  - Capture data/error from channel sel; go to RESP.
  - Acks from non-selected channels are ignored.
- FSM RESP:
  - inst_core_ack_o=1 for exactly this cycle, with registered data/error.
  - inst_core_req_i is ignored in this cycle; go to IDLE.
- Latency:
  - Decode error: ack in cycle 1.
  - Channel ack in cycle k (k>=1): core ack in cycle k+1.
  - Best case: 2 cycles. Max throughput: 1 fetch per 3 cycles.
- inst_core_data_o and inst_core_error_o hold their last values between acks; they are meaningful only with ack.
- An ack arriving in IDLE or RESP is dropped silently.
- Synchronous reset mid-transaction:
  - Next edge: IDLE; ch_req and core ack deasserted.
  - A late channel ack after reset is ignored.
- Single outstanding transaction: a core address change while busy has no effect, since the latched address is used.

Optional Feature:
- Macro INST_DEMUX_TIMEOUT_EN.
- With the macro:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES-1 with no ack, ch_req drops and the FSM goes to RESP with error=1, data=0.
  - An ack in the same cycle as expiry wins: normal response.
- Without the macro: no counter is present, and WAIT waits indefinitely.

Decomposition:
- Package inst_demux_pkg:
  - PAGE_W=20, PAGE_LSB=12 constants.
  - typedef enum logic[1:0] {IDLE, WAIT, RESP} demux_state_e.
  - typedef logic[31:0] inst_addr_t.
- One sub-module, inst_page_decoder: combinational; page, CH_BASE_PG and CH_END_PG in; one-hot sel and hit out, with lowest-index priority.
- FSM, latches and watchdog live in the top module.

Test Plan:
- Route to channel 1: req addr 0x00012344; ch1 acks in cycle 3 with data 0xDEADBEEF.
  - ch_req_o=3'b010 in cycles 1-3; core ack in cycle 4 with data 0xDEADBEEF, error 0.
- Unmapped address: req addr 0x00030000.
  - No ch_req; ack in cycle 1, error 1, data 0.
- Overlap priority: CH_BASE_PG/CH_END_PG for ch0 and ch2 both cover page 0x80000; req addr 0x80000000.
  - Only ch_req_o[0] rises.
- Stray ack: during WAIT on ch2, pulse inst_ch_ack_i[0].
  - Ignored; the response comes only after ch2 ack, with ch2 data.
- Mid-transaction reset: assert rst_i in cycle 2 of WAIT, then pulse ch ack in cycle 4.
  - ch_req=0 from cycle 3; no core ack; state IDLE.
- Timeout (INST_DEMUX_TIMEOUT_EN, TIMEOUT_CYCLES=8): ch0 never acks.
  - ch_req drops after 8 WAIT cycles; core ack with error 1. Without the macro: busy_o stays 1.
